// File: rtl/sigmoid_pwl_seed.sv
// Three-stage seed generator for the sigmoid reciprocal: y0 ~= 1/(1 + e^-x) via
// normalise-to-[1,2), linear fit C0 - C1*m, then denormalise; valid/ready with full backpressure.
module sigmoid_pwl_seed #(
  parameter int TAG_W = 4,
  parameter int C0    = 92521,
  parameter int C1    = 30840
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [19:0]      exp_in,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [19:0]      pwl_out,
  output logic [19:0]      exp_out,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [16:0] C0_L = 17'(C0);
  localparam logic [15:0] C1_L = 16'(C1);

  function automatic logic [2:0] lead_one(input logic [4:0] hi);
    logic [2:0] k;
    casez (hi)
      5'b1????: k = 3'd4;
      5'b01???: k = 3'd3;
      5'b001??: k = 3'd2;
      5'b0001?: k = 3'd1;
      default:  k = 3'd0;
    endcase
    return k;
  endfunction

  logic             v1_r, v2_r, v3_r;
  logic             en1_s, en2_s, en3_s;
  logic [20:0]      d1_r;
  logic [2:0]       k1_r, k2_r;
  logic [19:0]      exp1_r, exp2_r, exp3_r;
  logic [TAG_W-1:0] tag1_r, tag2_r, tag3_r;
  logic [15:0]      p2_r;
  logic [19:0]      pwl3_r;

  logic [20:0]      d_s;
  logic [2:0]       k_s;
  logic [16:0]      m_s;
  logic [15:0]      p_s;
  logic [16:0]      y_s;
  logic [19:0]      pwl_s;

  // Stage load enables: a stage loads when empty or when its content moves on.
  always_comb begin
    en3_s = !v3_r || out_ready;
    en2_s = !v2_r || en3_s;
    en1_s = !v1_r || en2_s;
  end

  assign in_ready = en1_s;

  // Datapath: denominator/exponent, normalised product, denormalised seed.
  always_comb begin
    d_s   = 21'd65536 + {1'b0, exp_in};
    k_s   = lead_one(d_s[20:16]);
    m_s   = 17'(d1_r >> k1_r);
    p_s   = 16'(({16'd0, C1_L} * {15'd0, m_s}) >> 16);
    y_s   = C0_L - {1'b0, p2_r};
    pwl_s = {3'b000, y_s >> k2_r};
  end

  // S1: capture d, its exponent and the sideband.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r   <= 1'b0;
      d1_r   <= 21'd0;
      k1_r   <= 3'd0;
      exp1_r <= 20'd0;
      tag1_r <= '0;
    end else if (en1_s) begin
      v1_r   <= in_valid;
      d1_r   <= d_s;
      k1_r   <= k_s;
      exp1_r <= exp_in;
      tag1_r <= in_tag;
    end
  end

  // S2: scaled slope term of the linear fit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r   <= 1'b0;
      p2_r   <= 16'd0;
      k2_r   <= 3'd0;
      exp2_r <= 20'd0;
      tag2_r <= '0;
    end else if (en2_s) begin
      v2_r   <= v1_r;
      p2_r   <= p_s;
      k2_r   <= k1_r;
      exp2_r <= exp1_r;
      tag2_r <= tag1_r;
    end
  end

  // S3: output register; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_r   <= 1'b0;
      pwl3_r <= 20'd0;
      exp3_r <= 20'd0;
      tag3_r <= '0;
    end else if (en3_s) begin
      v3_r   <= v2_r;
      pwl3_r <= pwl_s;
      exp3_r <= exp2_r;
      tag3_r <= tag2_r;
    end
  end

  assign out_valid = v3_r;
  assign pwl_out   = pwl3_r;
  assign exp_out   = exp3_r;
  assign out_tag   = tag3_r;

endmodule

// File: tb/tb_sigmoid_pwl_seed.sv
// Directed self-checking bench for sigmoid_pwl_seed: reset, known seeds, streaming,
// backpressure and mid-flight reset.
module tb_sigmoid_pwl_seed;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] exp_in;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] pwl_out;
  logic [19:0] exp_out;
  logic [3:0]  out_tag;

  int checks = 0;
  int errors = 0;

  sigmoid_pwl_seed #(.TAG_W(4), .C0(92521), .C1(30840)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .exp_in(exp_in), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .pwl_out(pwl_out), .exp_out(exp_out), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference seed from the arithmetic definition, in 64-bit integers.
  function automatic longint ref_pwl(input longint e);
    longint d, m, p, y;
    int k;
    d = 65536 + e;
    k = 0;
    for (int i = 0; i < 5; i++) if (((d >> (16 + i)) & 1) == 1) k = i;
    m = d >> k;
    p = (30840 * m) >> 16;
    y = 92521 - p;
    return y >> k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one sample into an idle pipe and wait for it; latency counts edges from the accepting one.
  task automatic send_one(input logic [19:0] e, input logic [3:0] t, output int lat,
                          output logic [19:0] pw, output logic [19:0] ex, output logic [3:0] tg);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    exp_in    = e;
    in_tag    = t;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    pw = pwl_out;
    ex = exp_out;
    tg = out_tag;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; exp_in = 20'd0; in_tag = 4'd0; out_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b0 || pwl_out !== 20'd0 || exp_out !== 20'd0 || out_tag !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b pwl=%0d exp=%h tag=%0d, want all 0",
               out_valid, pwl_out, exp_out, out_tag);
    end
    rst_n = 1'b1;
    repeat (2) tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_directed();
    logic [19:0] vec_e [4] = '{20'h00000, 20'h10000, 20'h08000, 20'hFFFFF};
    int          vec_y [4] = '{61681, 30840, 46261, 3734};
    int lat;
    logic [19:0] pw, ex;
    logic [3:0]  tg;
    for (int i = 0; i < 4; i++) begin
      send_one(vec_e[i], 4'(i + 3), lat, pw, ex, tg);
      checks++;
      if (lat !== 3) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d cycles, want 3", i, lat);
      end
      checks++;
      if (pw !== 20'(vec_y[i])) begin
        errors++;
        $display("FAIL directed_pwl[%0d]: exp_in=%h got %0d, want %0d", i, vec_e[i], pw, vec_y[i]);
      end
      checks++;
      if (ex !== vec_e[i] || tg !== 4'(i + 3)) begin
        errors++;
        $display("FAIL directed_side[%0d]: got exp=%h tag=%0d, want exp=%h tag=%0d",
                 i, ex, tg, vec_e[i], i + 3);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] vec [8] = '{20'h00000, 20'h10000, 20'h08000, 20'hFFFFF,
                             20'h00001, 20'h3FFFF, 20'h7FFFF, 20'h20000};
    int sent = 0, got = 0, cyc = 0, first = -1, last = -1;
    out_ready = 1'b1;
    while (got < 8 && cyc < 100) begin
      in_valid = (sent < 8);
      exp_in   = (sent < 8) ? vec[sent] : 20'd0;
      in_tag   = 4'(sent);
      @(negedge clk);
      if (out_valid && out_ready) begin
        checks++;
        if (pwl_out !== 20'(ref_pwl(longint'(vec[got]))) || exp_out !== vec[got] || out_tag !== 4'(got)) begin
          errors++;
          $display("FAIL b2b_out[%0d]: got pwl=%0d exp=%h tag=%0d, want pwl=%0d exp=%h tag=%0d",
                   got, pwl_out, exp_out, out_tag, ref_pwl(longint'(vec[got])), vec[got], got);
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got !== 8 || (last - first) !== 7) begin
      errors++;
      $display("FAIL b2b_rate: got %0d outputs over span %0d, want 8 over span 7", got, last - first);
    end
  endtask

  task automatic test_stall();
    logic [19:0] vec [5] = '{20'h12345, 20'h00800, 20'hABCDE, 20'h0F0F0, 20'h55555};
    int sent = 0, got = 0, cyc = 0, drop_at = -1;
    logic        held = 1'b0;
    logic [19:0] h_pwl, h_exp;
    logic [3:0]  h_tag;
    while (got < 5 && cyc < 100) begin
      out_ready = (cyc >= 2 && cyc <= 9) ? 1'b0 : 1'b1;
      in_valid  = (sent < 5);
      exp_in    = (sent < 5) ? vec[sent] : 20'd0;
      in_tag    = 4'(sent + 8);
      @(negedge clk);
      if (in_valid && !in_ready && drop_at < 0) drop_at = sent;
      if (out_valid && !out_ready) begin
        if (!held) begin
          held = 1'b1;
          h_pwl = pwl_out; h_exp = exp_out; h_tag = out_tag;
        end else begin
          checks++;
          if (pwl_out !== h_pwl || exp_out !== h_exp || out_tag !== h_tag) begin
            errors++;
            $display("FAIL stall_frozen: cycle %0d got pwl=%0d exp=%h tag=%0d, want %0d %h %0d",
                     cyc, pwl_out, exp_out, out_tag, h_pwl, h_exp, h_tag);
          end
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (pwl_out !== 20'(ref_pwl(longint'(vec[got]))) || exp_out !== vec[got] || out_tag !== 4'(got + 8)) begin
          errors++;
          $display("FAIL stall_out[%0d]: got pwl=%0d exp=%h tag=%0d, want pwl=%0d exp=%h tag=%0d",
                   got, pwl_out, exp_out, out_tag, ref_pwl(longint'(vec[got])), vec[got], got + 8);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (drop_at !== 3 || !held) begin
      errors++;
      $display("FAIL stall_in_ready: in_ready dropped after %0d samples (held=%b), want 3", drop_at, held);
    end
    checks++;
    if (got !== 5) begin
      errors++;
      $display("FAIL stall_count: got %0d outputs, want 5", got);
    end
  endtask

  task automatic test_reset_inflight();
    int lat, extra;
    logic [19:0] pw, ex;
    logic [3:0]  tg;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      exp_in   = 20'h12345 + 20'(i);
      in_tag   = 4'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL inflight_setup: got out_valid=%b, want 1", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || pwl_out !== 20'd0 || exp_out !== 20'd0 || out_tag !== 4'd0) begin
      errors++;
      $display("FAIL inflight_async_reset: got v=%b pwl=%0d exp=%h tag=%0d, want all 0",
               out_valid, pwl_out, exp_out, out_tag);
    end
    tick();
    rst_n = 1'b1;
    tick();
    send_one(20'h10000, 4'd9, lat, pw, ex, tg);
    checks++;
    if (lat !== 3 || pw !== 20'd30840 || ex !== 20'h10000 || tg !== 4'd9) begin
      errors++;
      $display("FAIL post_reset_first: got lat=%0d pwl=%0d exp=%h tag=%0d, want 3 30840 10000 9",
               lat, pw, ex, tg);
    end
    extra = 0;
    repeat (6) begin
      if (out_valid) extra++;
      tick();
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL post_reset_alone: got %0d extra output cycles, want 0", extra);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sigmoid_pwl_seed.md
Name: sigmoid_pwl_seed

Overview:
- Pipelined seed generator directly upstream of the Newton-Raphson reciprocal stage in the sigmoid datapath.
- Takes e^-x (unsigned Q4.16) and forms the denominator d = 1 + e^-x.
- Produces a linear-approximation seed y0 ≈ 1/d (Q4.16) on pwl_out.
- Forwards the matching exp value on exp_out so the pair feeds the NR stage's pwl_in/exp_in directly; valid/ready handshake with full backpressure.

Parameters:
- TAG_W, 4, width of the opaque sideband tag carried alongside each sample (≥1).
- C0, 92521, seed intercept 24/17 in Q.16.
- C1, 30840, seed slope 8/17 in Q.16.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts input this cycle
- exp_in  in  20  e^-x, unsigned Q4.16
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts output
- pwl_out  out  20  seed y0, unsigned Q4.16
- exp_out  out  20  exp_in of the same sample, unmodified
- out_tag  out  TAG_W  in_tag of the same sample

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0, all data registers 0, so out_valid=0 and pwl_out=exp_out=out_tag=0.
- Three register stages S1→S2→S3; S3 drives the outputs.
  - Stage n loads when it is empty or its content moves on this cycle.
  - S3 moves when out_valid && out_ready.
  - in_ready = S1 empty or S1 advancing; combinational path from out_ready is allowed.
- Latency: exactly 3 cycles from an accepted input to out_valid when out_ready=1 throughout. Throughput is 1 sample/cycle.
- Stall: while out_valid=1 and out_ready=0, all outputs hold stable. No sample is dropped, duplicated or reordered.
- S1:
  - d = 65536 + exp_in, 21 bits unsigned, range [0x10000, 0x10FFFF].
  - k = index of the leading one of d[20:16] (0..4); d[20]=1 → k=4.
  - Register d, k, exp_in, in_tag.
- S2:
  - m = d >> k, 17 bits in [65536, 131071] (truncating shift).
  - p = (C1 * m) >> 16; compute a 32-bit product, keep bits [31:16].
  - Register p, k, exp, tag.
- S3:
  - y = C0 − p; always positive, ≥ 30841 since m < 2.0.
  - pwl_out = zero-extend(y >> k), truncating.
  - exp_out and out_tag are the values captured in S1, unchanged.
- All arithmetic is unsigned. No saturation is needed: the full 20-bit exp_in range is legal.
- Reset mid-operation discards all in-flight samples immediately. The first post-reset output is the first sample accepted after release.
- Simultaneous accept at S1 and emit at S3 in the same cycle is legal and must not stall.

Test Plan:
- exp_in=0x00000, out_ready=1 → 3 cycles later out_valid=1, pwl_out=61681, exp_out=0x00000.
- exp_in=0x10000 (d=2.0, k=1) → pwl_out=30840; exp_in=0x08000 (d=1.5) → pwl_out=46261.
- exp_in=0xFFFFF (d=0x10FFFF, k=4, m=69631) → pwl_out=3734, exp_out=0xFFFFF.
- Back-to-back burst of 8 inputs, tags 0..7, out_ready=1 → outputs on 8 consecutive cycles, tags in order, each pwl_out matching a reference model.
- Burst of 5 with out_ready=0 for cycles 2..9:
  - in_ready drops after 3 samples are held.
  - Outputs stay frozen while stalled.
  - All 5 samples emerge in order after release.
- Reset asserted with 3 samples in flight → out_valid=0 and pwl_out=0 immediately (asynchronous). After release, the next input appears alone after 3 cycles.
